// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel front end: default pixel width, default
// number of stored lines, and the column-slice bit-offset helper.
package sobel_pkg;

  // Default pixel width in bits.
  localparam int SOBEL_DATA_W = 8;

  // Default count of stored previous lines (a 3x3 kernel needs two).
  localparam int SOBEL_ROWS = 2;

  // Bit offset of slice k in a packed column of dw-bit pixels.
  function automatic int col_lsb(input int k, input int dw);
    return k * dw;
  endfunction

endpackage

// File: rtl/sobel_line_mem.sv
// One image line of WIDTH pixels: a single write port plus a combinational
// read port that shares the write address, so a read-modify-shift of the
// same x happens within a single accept cycle.
module sobel_line_mem
  import sobel_pkg::*;
#(
  parameter  int DATA_W = SOBEL_DATA_W,
  parameter  int WIDTH  = 640,
  localparam int AW     = $clog2(WIDTH)
) (
  input  logic              CLOCK,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [WIDTH];

  // Line storage is deliberately never cleared; stale pixels are masked upstream.
  always_ff @(posedge CLOCK) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/sobel_row_buffer.sv
// Streaming multi-line buffer: for each accepted raster pixel, emits the
// vertical column {line ROWS-1 .. line 0, current} at the same x, zero-filling
// lines that have not yet arrived in the current frame.
module sobel_row_buffer
  import sobel_pkg::*;
#(
  parameter  int DATA_W = SOBEL_DATA_W,
  parameter  int WIDTH  = 640,
  parameter  int ROWS   = SOBEL_ROWS,
  localparam int AW     = $clog2(WIDTH)
) (
  input  logic                       CLOCK,
  input  logic                       RESET,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_sof,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [(ROWS+1)*DATA_W-1:0] out_col,
  output logic [AW-1:0]              out_x,
  output logic                       out_full,
  output logic                       out_eol
);

  localparam int RW = $clog2(ROWS + 1);
  localparam int CW = (ROWS + 1) * DATA_W;

  logic [AW-1:0]     x_reg;
  logic [AW-1:0]     eff_x;
  logic [AW-1:0]     x_next;
  logic [RW-1:0]     rcnt_reg;
  logic [RW-1:0]     eff_rcnt;
  logic [RW-1:0]     rcnt_next;
  logic              acc;
  logic              at_eol;
  logic [DATA_W-1:0] rd_data [ROWS];
  logic [DATA_W-1:0] wr_data [ROWS];
  logic [CW-1:0]     col_next;

  // A held output blocks new input; a drained or empty output register accepts.
  assign in_ready = ~out_valid | out_ready;
  assign acc      = in_valid & in_ready;

  // Start-of-frame overrides the stored position for the pixel it qualifies.
  assign eff_x    = in_sof ? '0 : x_reg;
  assign eff_rcnt = in_sof ? '0 : rcnt_reg;
  assign at_eol   = (eff_x == AW'(WIDTH - 1));

  assign x_next    = at_eol ? '0 : eff_x + AW'(1);
  assign rcnt_next = (!at_eol || eff_rcnt == RW'(ROWS)) ? eff_rcnt
                                                         : eff_rcnt + RW'(1);

  assign col_next[DATA_W-1:0] = in_data;

  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_line
      // Line 0 takes the new pixel; each older line takes its younger neighbour.
      if (gi == 0) begin : g_first
        assign wr_data[gi] = in_data;
      end else begin : g_shift
        assign wr_data[gi] = rd_data[gi-1];
      end

      sobel_line_mem #(
        .DATA_W (DATA_W),
        .WIDTH  (WIDTH)
      ) u_line (
        .CLOCK (CLOCK),
        .we    (acc),
        .addr  (eff_x),
        .wdata (wr_data[gi]),
        .rdata (rd_data[gi])
      );

      // Lines not yet received in this frame read back as zero.
      assign col_next[col_lsb(gi + 1, DATA_W) +: DATA_W] =
        (eff_rcnt >= RW'(gi + 1)) ? rd_data[gi] : '0;
    end
  endgenerate

  // Raster position: x wraps at line end, row count saturates at ROWS.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      x_reg    <= '0;
      rcnt_reg <= '0;
    end else if (acc) begin
      x_reg    <= x_next;
      rcnt_reg <= rcnt_next;
    end
  end

  // Output register: load on accept, drop valid once drained, hold while stalled.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      out_valid <= 1'b0;
      out_col   <= '0;
      out_x     <= '0;
      out_full  <= 1'b0;
      out_eol   <= 1'b0;
    end else if (acc) begin
      out_valid <= 1'b1;
      out_col   <= col_next;
      out_x     <= eff_x;
      out_full  <= (eff_rcnt >= RW'(ROWS));
      out_eol   <= at_eol;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sobel_row_buffer.sv
// Directed bench for sobel_row_buffer with WIDTH=4, ROWS=2, DATA_W=8.
module tb_sobel_row_buffer;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int R  = 2;

  logic              CLOCK = 1'b0;
  logic              RESET;
  logic              in_valid;
  logic              in_ready;
  logic [DW-1:0]     in_data;
  logic              in_sof;
  logic              out_valid;
  logic              out_ready;
  logic [(R+1)*DW-1:0] out_col;
  logic [1:0]        out_x;
  logic              out_full;
  logic              out_eol;

  int n_cmp = 0;
  int n_err = 0;

  sobel_row_buffer #(.DATA_W(DW), .WIDTH(W), .ROWS(R)) dut (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sof    (in_sof),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_col   (out_col),
    .out_x     (out_x),
    .out_full  (out_full),
    .out_eol   (out_eol)
  );

  always #5 CLOCK = ~CLOCK;

  function automatic logic [31:0] col3(input int s2, input int s1, input int s0);
    return {8'h00, 8'(s2), 8'(s1), 8'(s0)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_px(input string tag, input int s2, input int s1, input int s0,
                          input int x, input bit full, input bit eol);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_col"},   32'(out_col),   col3(s2, s1, s0));
    chk({tag, "_x"},     32'(out_x),     32'(x));
    chk({tag, "_full"},  32'(out_full),  32'(full));
    chk({tag, "_eol"},   32'(out_eol),   32'(eol));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_col"},   32'(out_col),   32'd0);
    chk({tag, "_x"},     32'(out_x),     32'd0);
    chk({tag, "_full"},  32'(out_full),  32'd0);
    chk({tag, "_eol"},   32'(out_eol),   32'd0);
    chk({tag, "_ready"}, 32'(in_ready),  32'd1);
  endtask

  task automatic push(input int d, input bit sof);
    in_valid = 1'b1;
    in_data  = 8'(d);
    in_sof   = sof;
    @(posedge CLOCK);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    $display("px in=%0d sof=%0b -> valid=%b col=%h x=%0d full=%b eol=%b",
             d, sof, out_valid, out_col, out_x, out_full, out_eol);
  endtask

  initial begin
    int row;
    int x;
    int k;
    int s1;
    int s2;
    int vals [12];
    bit v;

    RESET     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sof    = 1'b0;
    out_ready = 1'b0;

    // Reset: outputs clear asynchronously and stay clear across clock edges.
    #2 RESET = 1'b0;
    #1 check_zero("rst_async");
    repeat (2) @(posedge CLOCK);
    #1 check_zero("rst_held");
    @(negedge CLOCK);
    RESET     = 1'b1;
    out_ready = 1'b1;

    // Continuous frame 1..22: zero-fill, fill-up, saturation and wrap.
    for (int p = 1; p <= 22; p++) begin
      push(p, p == 1);
      row = (p - 1) / W;
      x   = (p - 1) % W;
      check_px($sformatf("p%0d", p), (row >= 2) ? p - 8 : 0, (row >= 1) ? p - 4 : 0,
               p, x, row >= 2, x == W - 1);
      if (p == 2)  chk("p2_hand",  32'(out_col), col3(0, 0, 2));
      if (p == 6)  chk("p6_hand",  32'(out_col), col3(0, 2, 6));
      if (p == 10) chk("p10_hand", 32'(out_col), col3(2, 6, 10));
      if (p == 12) chk("p12_eol",  32'(out_eol), 32'd1);
      if (p == 20) chk("row4_x3",  32'(out_col), col3(12, 16, 20));
    end

    // Backpressure mid-row: pixel 23 presented but blocked for 3 cycles.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'd23;
    for (int c = 0; c < 3; c++) begin
      @(posedge CLOCK);
      #1;
      $display("stall cycle %0d: in_ready=%b col=%h", c, in_ready, out_col);
      chk($sformatf("stall%0d_ready", c), 32'(in_ready),  32'd0);
      chk($sformatf("stall%0d_valid", c), 32'(out_valid), 32'd1);
      chk($sformatf("stall%0d_col", c),   32'(out_col),   col3(14, 18, 22));
      chk($sformatf("stall%0d_x", c),     32'(out_x),     32'd1);
    end
    out_ready = 1'b1;
    push(23, 1'b0);
    check_px("p23", 15, 19, 23, 2, 1'b1, 1'b0);
    push(24, 1'b0);
    check_px("p24", 16, 20, 24, 3, 1'b1, 1'b1);

    // New frame of 6 pixels, then restart on value 50.
    for (int i = 0; i < 6; i++) begin
      push(61 + i, i == 0);
      row = i / W;
      x   = i % W;
      check_px($sformatf("f2_%0d", i), 0, (row >= 1) ? 61 + i - 4 : 0, 61 + i, x, 1'b0,
               x == W - 1);
    end
    push(50, 1'b1);
    check_px("sof50", 0, 0, 50, 0, 1'b0, 1'b0);
    push(51, 1'b0);
    check_px("after50", 0, 0, 51, 1, 1'b0, 1'b0);

    // Bubbles: random input gaps, output follows each accept by one cycle.
    k = 0;
    for (int c = 0; c < 200 && k < 12; c++) begin
      v = (c == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      in_valid = v;
      in_data  = 8'(150 + k);
      in_sof   = v && (k == 0);
      @(posedge CLOCK);
      #1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
      $display("bubble cycle %0d: in_valid=%b -> valid=%b col=%h x=%0d",
               c, v, out_valid, out_col, out_x);
      chk($sformatf("bub%0d_valid", c), 32'(out_valid), 32'(v));
      if (v) begin
        vals[k] = 150 + k;
        row = k / W;
        x   = k % W;
        s1  = 0;
        s2  = 0;
        if (row >= 1) s1 = vals[k-4];
        if (row >= 2) s2 = vals[k-8];
        chk($sformatf("bub%0d_col", c),  32'(out_col),  col3(s2, s1, vals[k]));
        chk($sformatf("bub%0d_x", c),    32'(out_x),    32'(x));
        chk($sformatf("bub%0d_full", c), 32'(out_full), 32'(row >= 2));
        k++;
      end
    end
    chk("bub_count", 32'(k), 32'd12);

    // Reset asserted mid-row while out_valid is high.
    push(90, 1'b0);
    push(91, 1'b0);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b0;
    #2 RESET = 1'b0;
    #1 check_zero("rst_mid");
    @(negedge CLOCK);
    RESET     = 1'b1;
    out_ready = 1'b1;
    push(77, 1'b0);
    check_px("post_rst", 0, 0, 77, 0, 1'b0, 1'b0);
    push(78, 1'b0);
    check_px("post_rst2", 0, 0, 78, 1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
